// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizing for the detector-comparison sequencer.
// Enable the loop feature by defining SEQ_CTRL_LOOP_EN.
package seq_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DRAIN_DEF = 2;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic in_run(input state_e s);
    return (s == ST_SHIFT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/seq_ctrl_sat.sv
// Saturating event counter with synchronous clear; clear wins over enable.
// Exposes its next value so the parent can compare counts on the same edge.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/seq_ctrl.sv
// Drives a bit pattern serially into three detectors, counts their hits and flags disagreement.
// Optional SEQ_CTRL_LOOP_EN adds a loop input that re-runs the latched pattern from DONE.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DRAIN = DRAIN_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             det_moore,
  input  logic             det_mealy,
  input  logic             det_gate,
`ifdef SEQ_CTRL_LOOP_EN
  input  logic             loop,
`endif
  output logic             drv_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_moore,
  output logic [CNT_W-1:0] cnt_mealy,
  output logic [CNT_W-1:0] cnt_gate,
  output logic             mismatch
);

  // Down-counter must hold either a bit count or a drain count (DRAIN <= 7).
  localparam int DC_W = (LEN_W > 3) ? LEN_W : 3;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic             mismatch_q, mismatch_d;

  logic [LEN_W-1:0] len_c;
  logic             launch, launch_new, to_drain;
  logic [WIDTH-1:0] launch_pat;
  logic [LEN_W-1:0] launch_len;
  logic [CNT_W-1:0] nxt_moore, nxt_mealy, nxt_gate;

`ifdef SEQ_CTRL_LOOP_EN
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
`endif

  always_comb begin
    len_c      = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    launch_new = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    launch     = launch_new;
    launch_pat = pattern;
    launch_len = len_c;
`ifdef SEQ_CTRL_LOOP_EN
    if (!launch_new && (state_q == ST_DONE) && loop) begin
      launch     = 1'b1;
      launch_pat = pat_q;
      launch_len = len_q;
    end
    pat_d = launch_new ? pattern : pat_q;
    len_d = launch_new ? len_c : len_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    dc_d     = dc_q;
    to_drain = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        sh_d = sh_q << 1;
        if (dc_q == '0) begin
          to_drain = 1'b1;
        end else begin
          dc_d = dc_q - DC_W'(1);
        end
      end
      ST_DRAIN: begin
        if (dc_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dc_d = dc_q - DC_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (launch) begin
      sh_d = launch_pat;
      if (launch_len != '0) begin
        state_d = ST_SHIFT;
        dc_d    = DC_W'(launch_len) - DC_W'(1);
      end else begin
        to_drain = 1'b1;
      end
    end

    // A zero-length drain skips the DRAIN state entirely.
    if (to_drain) begin
      if (DRAIN == 0) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_DRAIN;
        dc_d    = DC_W'((DRAIN > 0) ? DRAIN - 1 : 0);
      end
    end

    mismatch_d = launch_new ? 1'b0 : mismatch_q;
    if ((state_d == ST_DONE) && !((nxt_moore == nxt_mealy) && (nxt_mealy == nxt_gate))) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      dc_q       <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      dc_q       <= dc_d;
      mismatch_q <= mismatch_d;
    end
  end

`ifdef SEQ_CTRL_LOOP_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat_q <= '0;
      len_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
    end
  end
`endif

  assign busy     = in_run(state_q);
  assign done     = (state_q == ST_DONE);
  assign drv_in   = (state_q == ST_SHIFT) && sh_q[WIDTH-1];
  assign mismatch = mismatch_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_moore (
    .clk(clk), .rstn(rstn), .clr(launch), .en(busy && det_moore),
    .cnt(cnt_moore), .cnt_nxt(nxt_moore)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_mealy (
    .clk(clk), .rstn(rstn), .clr(launch), .en(busy && det_mealy),
    .cnt(cnt_mealy), .cnt_nxt(nxt_mealy)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_gate (
    .clk(clk), .rstn(rstn), .clr(launch), .en(busy && det_gate),
    .cnt(cnt_gate), .cnt_nxt(nxt_gate)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// Randomized bench for seq_ctrl: a default instance and a CNT_W=2 instance share stimulus
// and are compared every cycle against a run-timeline reference model.
module tb_seq_ctrl;

  localparam int W     = 16;
  localparam int DRN   = 2;
  localparam int LW    = 5;
  localparam int SAT_A = 255;
  localparam int SAT_B = 3;
  localparam int NCYC  = 3000;
`ifdef SEQ_CTRL_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, start, loop;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic          det_moore, det_mealy, det_gate;

  logic          drv_a, busy_a, done_a, mis_a;
  logic [7:0]    cmo_a, cme_a, cga_a;
  logic          drv_b, busy_b, done_b, mis_b;
  logic [1:0]    cmo_b, cme_b, cga_b;

  always #5 clk = ~clk;

  seq_ctrl u_dut_a (
    .clk(clk), .rstn(rstn), .start(start), .pattern(pattern), .len(len),
    .det_moore(det_moore), .det_mealy(det_mealy), .det_gate(det_gate),
`ifdef SEQ_CTRL_LOOP_EN
    .loop(loop),
`endif
    .drv_in(drv_a), .busy(busy_a), .done(done_a),
    .cnt_moore(cmo_a), .cnt_mealy(cme_a), .cnt_gate(cga_a), .mismatch(mis_a)
  );

  seq_ctrl #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start), .pattern(pattern), .len(len),
    .det_moore(det_moore), .det_mealy(det_mealy), .det_gate(det_gate),
`ifdef SEQ_CTRL_LOOP_EN
    .loop(loop),
`endif
    .drv_in(drv_b), .busy(busy_b), .done(done_b),
    .cnt_moore(cmo_b), .cnt_mealy(cme_b), .cnt_gate(cga_b), .mismatch(mis_b)
  );

  // Reference model: a run is a timeline of len drive cycles, DRN settle cycles, one done cycle.
  bit           m_run;
  int           m_t, m_len;
  logic [W-1:0] m_pat;
  int           raw [3];
  bit           m_mis_a, m_mis_b;
  int           checks = 0;
  int           errors = 0;
  int           det_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit differ(input int mx);
    return (sat(raw[0], mx) != sat(raw[1], mx)) || (sat(raw[1], mx) != sat(raw[2], mx));
  endfunction

  function automatic bit exp_busy();
    return m_run && (m_t <= m_len + DRN);
  endfunction

  function automatic bit exp_done();
    return m_run && (m_t == m_len + DRN + 1);
  endfunction

  task automatic check_outputs();
    logic e_drv;
    e_drv = (m_run && (m_t <= m_len)) ? m_pat[W - m_t] : 1'b0;
    chk("drv_a",  32'(drv_a),  32'(e_drv));
    chk("busy_a", 32'(busy_a), 32'(exp_busy()));
    chk("done_a", 32'(done_a), 32'(exp_done()));
    chk("drv_b",  32'(drv_b),  32'(e_drv));
    chk("busy_b", 32'(busy_b), 32'(exp_busy()));
    chk("done_b", 32'(done_b), 32'(exp_done()));
    chk("cnt_moore_a", 32'(cmo_a), 32'(sat(raw[0], SAT_A)));
    chk("cnt_mealy_a", 32'(cme_a), 32'(sat(raw[1], SAT_A)));
    chk("cnt_gate_a",  32'(cga_a), 32'(sat(raw[2], SAT_A)));
    chk("cnt_moore_b", 32'(cmo_b), 32'(sat(raw[0], SAT_B)));
    chk("cnt_mealy_b", 32'(cme_b), 32'(sat(raw[1], SAT_B)));
    chk("cnt_gate_b",  32'(cga_b), 32'(sat(raw[2], SAT_B)));
    chk("mismatch_a",  32'(mis_a), 32'(m_mis_a));
    chk("mismatch_b",  32'(mis_b), 32'(m_mis_b));
  endtask

  // Advances the model across the coming rising edge using the inputs now applied.
  task automatic step_model();
    bit eb, ed;
    int lc;
    eb = exp_busy();
    ed = exp_done();
    if (!rstn) begin
      m_run   = 1'b0;
      m_t     = 0;
      raw     = '{0, 0, 0};
      m_mis_a = 1'b0;
      m_mis_b = 1'b0;
      return;
    end
    if (eb) begin
      raw[0] += int'(det_moore);
      raw[1] += int'(det_mealy);
      raw[2] += int'(det_gate);
    end
    if (start && !eb) begin
      lc      = int'(len);
      m_len   = (lc > W) ? W : lc;
      m_pat   = pattern;
      raw     = '{0, 0, 0};
      m_mis_a = 1'b0;
      m_mis_b = 1'b0;
      m_run   = 1'b1;
      m_t     = 1;
    end else if (ed && loop && LOOP_EN) begin
      raw = '{0, 0, 0};
      m_t = 1;
    end else if (ed) begin
      m_run = 1'b0;
    end else if (m_run) begin
      m_t++;
    end
    if (m_run && (m_t == m_len + DRN + 1)) begin
      m_mis_a = m_mis_a | differ(SAT_A);
      m_mis_b = m_mis_b | differ(SAT_B);
    end
  endtask

  task automatic pick_dets();
    logic b;
    b = 1'($urandom_range(0, 1));
    case (det_mode)
      0: {det_moore, det_mealy, det_gate} = 3'b111;
      1: {det_moore, det_mealy, det_gate} = {b, b, b};
      default: {det_moore, det_mealy, det_gate} = 3'($urandom_range(0, 7));
    endcase
  endtask

  initial begin
    int lsel;
    rstn      = 1'b0;
    start     = 1'b0;
    loop      = 1'b0;
    pattern   = '0;
    len       = '0;
    det_moore = 1'b0;
    det_mealy = 1'b0;
    det_gate  = 1'b0;
    det_mode  = 0;
    m_run     = 1'b0;
    m_t       = 0;
    m_len     = 0;
    m_pat     = '0;
    raw       = '{0, 0, 0};
    m_mis_a   = 1'b0;
    m_mis_b   = 1'b0;
    step_model();

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c > 0) check_outputs();

      rstn = !((c < 2) || ((c > 10) && ($urandom_range(0, 149) == 0)));
      if (c == 2) begin
        start    = 1'b1;
        pattern  = 16'hA000;
        len      = 5'd4;
        det_mode = 0;
      end else begin
        start   = ($urandom_range(0, 3) == 0);
        pattern = W'($urandom);
        lsel    = $urandom_range(0, 7);
        case (lsel)
          0: len = 5'd0;
          1: len = 5'd16;
          2: len = 5'd31;
          3: len = 5'd4;
          default: len = LW'($urandom_range(0, 31));
        endcase
        if (start && !exp_busy()) det_mode = $urandom_range(0, 2);
      end
      loop = 1'($urandom_range(0, 1));
      pick_dets();
      step_model();
    end

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, maximum pattern length in bits.
REQ-002 Parameter DRAIN, default 2, settle cycles after the last bit is driven (range 0..7).
REQ-003 Parameter CNT_W, default 8, width of each detection counter.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rstn  in  1  synchronous reset, active-low.
REQ-006 start  in  1  request to run one pattern; sampled only in IDLE or DONE.
REQ-007 pattern  in  WIDTH  bit pattern, driven MSB first.
REQ-008 len  in  $clog2(WIDTH)+1  number of bits to drive; values above WIDTH are clamped to WIDTH.
REQ-009 det_moore, det_mealy, det_gate  in  1 each  detector outputs under test.
REQ-010 drv_in  out  1  serial bit fed to all three detectors.
REQ-011 busy  out  1  high in SHIFT and DRAIN.
REQ-012 done  out  1  one-cycle pulse in DONE.
REQ-013 cnt_moore, cnt_mealy, cnt_gate  out  CNT_W each  detection counts.
REQ-014 mismatch  out  1  high when the three counts differ; valid while done=1 and held afterwards.

Function
REQ-015 The FSM SHALL have four states: IDLE, SHIFT, DRAIN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch pattern and min(len,WIDTH), clear all counters and mismatch, and enter SHIFT on the next cycle.
REQ-017 In SHIFT, drv_in SHALL equal pattern[WIDTH-1-k] in the k-th SHIFT cycle, counting k from 0.
REQ-018 After len SHIFT cycles the FSM SHALL enter DRAIN; a latched len of 0 SHALL go directly from start to DRAIN.
REQ-019 The FSM SHALL remain in DRAIN for DRAIN cycles, then enter DONE; with DRAIN=0 it SHALL pass through DRAIN for zero cycles (SHIFT goes straight to DONE).
REQ-020 drv_in SHALL be 0 in every state other than SHIFT.
REQ-021 In each SHIFT or DRAIN cycle, every counter whose det_* input is 1 SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-022 det_* inputs SHALL be ignored in IDLE and DONE.
REQ-023 When DONE is entered, mismatch SHALL be set to 1 unless all three counts are equal.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE unless start=1 (REQ-016).
REQ-025 start SHALL be ignored while busy=1.
REQ-026 Counters and mismatch SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 While rstn=0 at a clock edge, the FSM SHALL enter IDLE, and drv_in, busy, done, all counters and mismatch SHALL become 0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-029 After rstn returns to 1, the block SHALL accept start in the first cycle.

Configuration
REQ-030 Macro SEQ_CTRL_LOOP_EN, when defined, SHALL add input port loop (1 bit).
REQ-031 With SEQ_CTRL_LOOP_EN defined and loop=1 in DONE, the block SHALL restart SHIFT with the latched pattern and len without needing start.
REQ-032 A looped restart SHALL clear the counters but leave mismatch sticky until the next start-initiated run.
REQ-033 Without SEQ_CTRL_LOOP_EN, the loop port SHALL be absent and behaviour SHALL be exactly as REQ-015..REQ-026.

Structure
REQ-034 Package seq_ctrl_pkg SHALL hold the state enum and the default values of WIDTH, DRAIN and CNT_W.
REQ-035 A sub-module sat_counter (CNT_W wide, with clear and enable) SHALL be instantiated three times, once per detector.
REQ-036 A down-counter for the bit and drain count, plus a shift register for the pattern, SHALL live in seq_ctrl itself.

Verification
REQ-037 Reset then start, pattern=16'hA000, len=4 -> drv_in shows 1,0,1,0 in the four cycles after start, then 0; done pulses on cycle 1+4+2=7 after start.
REQ-038 Dets held at 1 throughout a run with len=16, DRAIN=2 -> all counts =18, mismatch=0.
REQ-039 det_mealy=1 for 3 cycles, det_moore=1 for 2 cycles, det_gate=1 for 3 cycles -> counts 2/3/3, mismatch=1 at done.
REQ-040 len=0 with start -> no SHIFT cycles, done 1+DRAIN cycles after start; len=31 -> 16 bits driven.
REQ-041 CNT_W=2, dets held at 1 for 10 cycles -> counts saturate at 3; a second start during busy is ignored.
REQ-042 rstn=0 in the middle of SHIFT -> next cycle busy=0, counts=0, and no done pulse occurs; with SEQ_CTRL_LOOP_EN and loop=1 -> consecutive runs without start.
